// File: rtl/write_fsm_controller_if.sv
// Write-path controller bus: MC/counter flags and config in, state code and enables out.
// The master side is the MC plus the write counters; the slave side is the controller.
interface write_fsm_controller_if;
  logic       wr_en;
  logic [1:0] burstlength;
  logic       dram_crc_en;
  logic       phy_crc_mode;
  logic       preamble_done;
  logic       wrdata_done;
  logic       wrdata_crc_done;
  logic       data_burst_done;
  logic       postamble_done;
  logic       interamble_done;
  logic       interamble;
  logic [2:0] fsm_state;
  logic       dqs_oe;
  logic       dq_oe;
  logic       crc_insert;
  logic       busy;
  logic       timeout;

  modport master (
    output wr_en, burstlength, dram_crc_en, phy_crc_mode,
    output preamble_done, wrdata_done, wrdata_crc_done, data_burst_done,
    output postamble_done, interamble_done, interamble,
    input  fsm_state, dqs_oe, dq_oe, crc_insert, busy, timeout
  );

  modport slave (
    input  wr_en, burstlength, dram_crc_en, phy_crc_mode,
    input  preamble_done, wrdata_done, wrdata_crc_done, data_burst_done,
    input  postamble_done, interamble_done, interamble,
    output fsm_state, dqs_oe, dq_oe, crc_insert, busy, timeout
  );
endinterface

// File: rtl/write_fsm_controller.sv
// DDR5 PHY write-path sequencer: preamble, data (+CRC / burst extension), interamble or
// postamble, with registered Moore enables and a stuck-state watchdog.
module write_fsm_controller #(
  parameter int unsigned CRC_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic                   i_clk,
  input logic                   i_rst,
  write_fsm_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    PRE    = 3'b001,
    WRCRC  = 3'b010,
    POST   = 3'b011,
    INTER  = 3'b100,
    WRDATA = 3'b101,
    BURST  = 3'b110,
    CRC    = 3'b111
  } state_t;

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW  = $clog2(CRC_CYCLES + 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CRC_LAST = CW'(CRC_CYCLES - 1);

  state_t         state;
  state_t         next_state;
  state_t         resolve_state;
  state_t         data_state;
  logic [1:0]     bl;
  logic           mc_crc;
  logic           phy_crc;
  logic [WDW-1:0] wd;
  logic [CW-1:0]  crc_cnt;
  logic           relatch;
  logic           resolve_relatch;
  logic           wd_expire;
  logic           in_mc_crc;
  logic           in_phy_crc;
  logic           dqs_oe_q;
  logic           dq_oe_q;
  logic           crc_insert_q;
  logic           busy_q;
  logic           timeout_q;

  always_comb begin
    in_mc_crc  = bus.dram_crc_en & ~bus.phy_crc_mode;
    in_phy_crc = bus.dram_crc_en & bus.phy_crc_mode;
    // A follow-on burst picks its data state from the config it is about to latch.
    data_state = in_mc_crc ? WRCRC : WRDATA;

    resolve_relatch = 1'b0;
    if (bus.wr_en && bus.interamble) begin
      resolve_state = INTER;
    end else if (bus.wr_en) begin
      resolve_state   = data_state;
      resolve_relatch = 1'b1;
    end else begin
      resolve_state = POST;
    end

    wd_expire  = (state != IDLE) && (wd >= WD_LAST);
    next_state = state;
    relatch    = 1'b0;

    if (wd_expire) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:   if (bus.wr_en) begin
                  next_state = PRE;
                  relatch    = 1'b1;
                end
        PRE:    if (bus.preamble_done) next_state = mc_crc ? WRCRC : WRDATA;
        WRDATA: if (bus.wrdata_done) begin
                  if (bl == 2'b10) begin
                    next_state = BURST;
                  end else if (phy_crc) begin
                    next_state = CRC;
                  end else begin
                    next_state = resolve_state;
                    relatch    = resolve_relatch;
                  end
                end
        BURST:  if (bus.data_burst_done) begin
                  if (phy_crc) begin
                    next_state = CRC;
                  end else begin
                    next_state = resolve_state;
                    relatch    = resolve_relatch;
                  end
                end
        WRCRC:  if (bus.wrdata_crc_done) begin
                  next_state = resolve_state;
                  relatch    = resolve_relatch;
                end
        CRC:    if (crc_cnt == CRC_LAST) begin
                  next_state = resolve_state;
                  relatch    = resolve_relatch;
                end
        INTER:  if (bus.interamble_done) begin
                  next_state = data_state;
                  relatch    = 1'b1;
                end
        POST:   if (bus.postamble_done || bus.wr_en) begin
                  next_state = bus.wr_en ? PRE : IDLE;
                  relatch    = bus.wr_en;
                end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      bl           <= '0;
      mc_crc       <= 1'b0;
      phy_crc      <= 1'b0;
      wd           <= '0;
      crc_cnt      <= '0;
      dqs_oe_q     <= 1'b0;
      dq_oe_q      <= 1'b0;
      crc_insert_q <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state <= next_state;

      if (wd_expire) begin
        bl      <= '0;
        mc_crc  <= 1'b0;
        phy_crc <= 1'b0;
      end else if (relatch) begin
        bl      <= bus.burstlength;
        mc_crc  <= in_mc_crc;
        phy_crc <= in_phy_crc;
      end

      if (next_state != state || next_state == IDLE) begin
        wd <= '0;
      end else if (wd != WD_MAX) begin
        wd <= wd + 1'b1;
      end

      if (next_state == CRC && state != CRC) begin
        crc_cnt <= '0;
      end else if (state == CRC) begin
        crc_cnt <= crc_cnt + 1'b1;
      end

      // Enables are decoded from the next state so they line up with the state register.
      dqs_oe_q     <= (next_state != IDLE);
      dq_oe_q      <= (next_state == WRDATA) || (next_state == WRCRC) ||
                      (next_state == BURST)  || (next_state == CRC);
      crc_insert_q <= (next_state == CRC);
      busy_q       <= (next_state != IDLE);
      timeout_q    <= wd_expire;
    end
  end

  assign bus.fsm_state  = state;
  assign bus.dqs_oe     = dqs_oe_q;
  assign bus.dq_oe      = dq_oe_q;
  assign bus.crc_insert = crc_insert_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_write_fsm_controller.sv
// Scenario bench for write_fsm_controller: per-cycle stimulus plans with a queue of
// expected {state, dqs_oe, dq_oe, crc_insert, busy, timeout} vectors.
module tb_write_fsm_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  write_fsm_controller_if bus ();

  write_fsm_controller #(
    .CRC_CYCLES(1),
    .TIMEOUT   (64)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // stimulus bits: wr_en, pre_done, wrdata_done, crc_done, burst_done, post_done, inter_done, interamble
  localparam logic [7:0] W   = 8'h80;
  localparam logic [7:0] PD  = 8'h40;
  localparam logic [7:0] WD  = 8'h20;
  localparam logic [7:0] CD  = 8'h10;
  localparam logic [7:0] BD  = 8'h08;
  localparam logic [7:0] POD = 8'h04;
  localparam logic [7:0] ID  = 8'h02;
  localparam logic [7:0] IA  = 8'h01;
  localparam logic [7:0] N0  = 8'h00;
  // config: {burstlength, dram_crc_en, phy_crc_mode}
  localparam logic [3:0] BL16_OFF = 4'b0100;
  localparam logic [3:0] BL32_PHY = 4'b1011;
  localparam logic [3:0] BL16_MC  = 4'b0110;
  localparam logic [3:0] BL32_MC  = 4'b1010;

  typedef struct packed {
    logic [7:0] v;
    logic [3:0] cfg;
    logic [2:0] st;
    logic       to;
  } item_t;

  item_t      plan[$];
  logic [7:0] sb[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] model(input logic [2:0] st, input logic to);
    return {st, st != 3'd0,
            (st == 3'd5) || (st == 3'd2) || (st == 3'd6) || (st == 3'd7),
            st == 3'd7, st != 3'd0, to};
  endfunction

  function automatic logic [7:0] obs();
    return {bus.fsm_state, bus.dqs_oe, bus.dq_oe, bus.crc_insert, bus.busy, bus.timeout};
  endfunction

  task automatic apply(input item_t p);
    bus.wr_en           = p.v[7];
    bus.preamble_done   = p.v[6];
    bus.wrdata_done     = p.v[5];
    bus.wrdata_crc_done = p.v[4];
    bus.data_burst_done = p.v[3];
    bus.postamble_done  = p.v[2];
    bus.interamble_done = p.v[1];
    bus.interamble      = p.v[0];
    bus.burstlength     = p.cfg[3:2];
    bus.dram_crc_en     = p.cfg[1];
    bus.phy_crc_mode    = p.cfg[0];
  endtask

  task automatic seg(input logic [7:0] v, input logic [3:0] cfg, input logic [2:0] st,
                     input logic to, input int n);
    item_t p;
    p = '{v: v, cfg: cfg, st: st, to: to};
    for (int i = 0; i < n; i++) plan.push_back(p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    item_t p;
    logic [7:0] e, o;
    p = '{v: N0, cfg: 4'b0000, st: 3'd0, to: 1'b0};
    apply(p);
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 8'h00) begin
      failures++;
      $display("FAIL reset_initial got %b required %b", obs(), 8'h00);
    end
    tick();
    tick();
    rst = 1'b0;
    seg(W, BL16_OFF, 3'd1, 1'b0, 1);
    seg(PD, BL16_OFF, 3'd5, 1'b0, 1);
    seg(N0, BL16_OFF, 3'd5, 1'b0, 2);
    while (plan.size() > 0) begin
      p = plan.pop_front();
      apply(p);
      sb.push_back(model(p.st, p.to));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_prelude got %b required %b", o, e);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 8'h00) begin
      failures++;
      $display("FAIL reset_async got %b required %b", obs(), 8'h00);
    end
    tick();
    checks++;
    if (obs() !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold got %b required %b", obs(), 8'h00);
    end
    rst = 1'b0;
    seg(W, BL16_OFF, 3'd1, 1'b0, 1);
    seg(N0, BL16_OFF, 3'd1, 1'b0, 1);
    seg(PD, BL16_OFF, 3'd5, 1'b0, 1);
    seg(WD, BL16_OFF, 3'd3, 1'b0, 1);
    seg(POD, BL16_OFF, 3'd0, 1'b0, 1);
    while (plan.size() > 0) begin
      p = plan.pop_front();
      apply(p);
      sb.push_back(model(p.st, p.to));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_restart got %b required %b", o, e);
      end
    end
  endtask

  task automatic test_bl16();
    item_t p;
    logic [7:0] e, o;
    seg(W, BL16_OFF, 3'd1, 1'b0, 1);
    seg(N0, BL16_OFF, 3'd1, 1'b0, 3);
    seg(PD, BL16_OFF, 3'd5, 1'b0, 1);
    seg(POD, BL16_OFF, 3'd5, 1'b0, 1);
    seg(N0, BL16_OFF, 3'd5, 1'b0, 6);
    seg(WD, BL16_OFF, 3'd3, 1'b0, 1);
    seg(N0, BL16_OFF, 3'd3, 1'b0, 1);
    seg(POD, BL16_OFF, 3'd0, 1'b0, 1);
    seg(N0, BL16_OFF, 3'd0, 1'b0, 1);
    while (plan.size() > 0) begin
      p = plan.pop_front();
      apply(p);
      sb.push_back(model(p.st, p.to));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL bl16 got %b required %b", o, e);
      end
    end
  endtask

  task automatic test_bl32_phy_crc();
    item_t p;
    logic [7:0] e, o;
    seg(W, BL32_PHY, 3'd1, 1'b0, 1);
    seg(PD, BL32_PHY, 3'd5, 1'b0, 1);
    seg(BD, BL32_PHY, 3'd5, 1'b0, 1);
    seg(N0, BL32_PHY, 3'd5, 1'b0, 2);
    seg(WD, BL32_PHY, 3'd6, 1'b0, 1);
    seg(N0, BL32_PHY, 3'd6, 1'b0, 2);
    seg(BD, BL32_PHY, 3'd7, 1'b0, 1);
    seg(N0, BL32_PHY, 3'd3, 1'b0, 1);
    seg(POD, BL32_PHY, 3'd0, 1'b0, 1);
    while (plan.size() > 0) begin
      p = plan.pop_front();
      apply(p);
      sb.push_back(model(p.st, p.to));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL bl32_phy_crc got %b required %b", o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    item_t p;
    logic [7:0] e, o;
    seg(W, BL16_OFF, 3'd1, 1'b0, 1);
    seg(PD, BL16_OFF, 3'd5, 1'b0, 1);
    seg(N0, BL16_OFF, 3'd5, 1'b0, 1);
    seg(WD | W | IA, BL16_OFF, 3'd4, 1'b0, 1);
    seg(N0, BL16_OFF, 3'd4, 1'b0, 1);
    seg(ID, BL16_OFF, 3'd5, 1'b0, 1);
    seg(N0, BL16_OFF, 3'd5, 1'b0, 1);
    seg(WD | W, BL16_OFF, 3'd5, 1'b0, 1);
    seg(N0, BL16_OFF, 3'd5, 1'b0, 2);
    seg(WD, BL16_OFF, 3'd3, 1'b0, 1);
    seg(W, BL16_OFF, 3'd1, 1'b0, 1);
    seg(PD, BL16_OFF, 3'd5, 1'b0, 1);
    seg(WD, BL16_OFF, 3'd3, 1'b0, 1);
    seg(POD, BL16_OFF, 3'd0, 1'b0, 1);
    while (plan.size() > 0) begin
      p = plan.pop_front();
      apply(p);
      sb.push_back(model(p.st, p.to));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL back_to_back got %b required %b", o, e);
      end
    end
  endtask

  task automatic test_mc_crc();
    item_t p;
    logic [7:0] e, o;
    seg(W, BL16_MC, 3'd1, 1'b0, 1);
    seg(PD, BL16_MC, 3'd2, 1'b0, 1);
    seg(WD, BL32_MC, 3'd2, 1'b0, 1);
    seg(N0, BL32_MC, 3'd2, 1'b0, 1);
    seg(CD, BL32_MC, 3'd3, 1'b0, 1);
    seg(POD, BL32_MC, 3'd0, 1'b0, 1);
    seg(W, BL16_OFF, 3'd1, 1'b0, 1);
    seg(PD, BL16_OFF, 3'd5, 1'b0, 1);
    seg(N0, BL32_PHY, 3'd5, 1'b0, 1);
    seg(WD, BL32_PHY, 3'd3, 1'b0, 1);
    seg(POD, BL32_PHY, 3'd0, 1'b0, 1);
    while (plan.size() > 0) begin
      p = plan.pop_front();
      apply(p);
      sb.push_back(model(p.st, p.to));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mc_crc got %b required %b", o, e);
      end
    end
  endtask

  task automatic test_timeout();
    item_t p;
    logic [7:0] e, o;
    seg(W, BL16_OFF, 3'd1, 1'b0, 1);
    seg(PD, BL16_OFF, 3'd5, 1'b0, 1);
    seg(WD, BL16_OFF, 3'd3, 1'b0, 1);
    seg(N0, BL16_OFF, 3'd3, 1'b0, 63);
    seg(N0, BL16_OFF, 3'd0, 1'b1, 1);
    seg(N0, BL16_OFF, 3'd0, 1'b0, 2);
    while (plan.size() > 0) begin
      p = plan.pop_front();
      apply(p);
      sb.push_back(model(p.st, p.to));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL timeout got %b required %b", o, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit got running required finished");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_bl16();
    test_bl32_phy_crc();
    test_back_to_back();
    test_mc_crc();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
